// File: rtl/calc_add_controller_if.sv
// Bus bundle between calc_add_controller (master side) and the calculator wrapper,
// the shared SRAM and the adder32 instance (slave side).
interface calc_add_controller_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int MEM_W  = 2 * DATA_W
);
    logic              start_i;
    logic [ADDR_W-1:0] read_start_addr_i;
    logic [ADDR_W-1:0] read_end_addr_i;
    logic [ADDR_W-1:0] write_start_addr_i;

    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_rd_addr_o;
    logic [MEM_W-1:0]  mem_rd_data_i;

    logic              mem_wr_en_o;
    logic [ADDR_W-1:0] mem_wr_addr_o;
    logic [MEM_W-1:0]  mem_wr_data_o;

    logic [DATA_W-1:0] op_a_o;
    logic [DATA_W-1:0] op_b_o;
    logic [DATA_W-1:0] sum_i;

    logic              busy_o;
    logic              done_o;
    logic              carry_o;

    modport master (
        input  start_i, read_start_addr_i, read_end_addr_i, write_start_addr_i,
        input  mem_rd_data_i, sum_i,
        output mem_rd_en_o, mem_rd_addr_o,
        output mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o,
        output op_a_o, op_b_o,
        output busy_o, done_o, carry_o
    );

    modport slave (
        output start_i, read_start_addr_i, read_end_addr_i, write_start_addr_i,
        output mem_rd_data_i, sum_i,
        input  mem_rd_en_o, mem_rd_addr_o,
        input  mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o,
        input  op_a_o, op_b_o,
        input  busy_o, done_o, carry_o
    );
endinterface

// File: rtl/calc_add_controller.sv
// Sequencer that feeds operand pairs to adder32 and packs two sums per result word.
// Optional macro CALC_CARRY_FLAG_EN enables the sticky unsigned-overflow flag carry_o.
module calc_add_controller #(
    parameter int ADDR_W = 10,
    parameter int MEM_W  = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    calc_add_controller_if.master bus
);
    localparam int DATA_W = MEM_W / 2;

    typedef enum logic [2:0] {IDLE, READ, ADD, STORE, WRITE, DONE} state_t;

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [MEM_W-1:0]  result_buf;
    logic              half;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              carry;

    logic              rd_en;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic              last_operand;

    assign last_operand = (rd_addr == end_addr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.read_end_addr_i < bus.read_start_addr_i) begin
                        next_state = DONE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:  next_state = ADD;
            ADD:   next_state = STORE;
            // half==1 means this sum fills the upper slot, so the word is complete
            STORE: next_state = (half || last_operand) ? WRITE : READ;
            WRITE: next_state = last_operand ? DONE : READ;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        wr_en = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        case (state)
            IDLE:    busy  = 1'b0;
            READ:    rd_en = 1'b1;
            WRITE:   wr_en = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_addr    <= '0;
            end_addr   <= '0;
            wr_addr    <= '0;
            result_buf <= '0;
            half       <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        rd_addr    <= bus.read_start_addr_i;
                        end_addr   <= bus.read_end_addr_i;
                        wr_addr    <= bus.write_start_addr_i;
                        result_buf <= '0;
                        half       <= 1'b0;
                    end
                end
                ADD: begin
                    op_a <= bus.mem_rd_data_i[MEM_W-1:DATA_W];
                    op_b <= bus.mem_rd_data_i[DATA_W-1:0];
                end
                STORE: begin
                    if (half) begin
                        result_buf[MEM_W-1:DATA_W] <= bus.sum_i;
                    end else begin
                        result_buf[DATA_W-1:0] <= bus.sum_i;
                    end
                    half <= ~half;
                    if (!half && !last_operand) begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                WRITE: begin
                    wr_addr    <= wr_addr + 1'b1;
                    result_buf <= '0;
                    half       <= 1'b0;
                    if (!last_operand) begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CALC_CARRY_FLAG_EN
    // A modulo-2^32 sum smaller than one addend means the add wrapped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            carry <= 1'b0;
        end else if (state == IDLE && bus.start_i) begin
            carry <= 1'b0;
        end else if (state == STORE && bus.sum_i < op_a) begin
            carry <= 1'b1;
        end
    end
`else
    assign carry = 1'b0;
`endif

    assign bus.mem_rd_en_o   = rd_en;
    assign bus.mem_rd_addr_o = rd_addr;
    assign bus.mem_wr_en_o   = wr_en;
    assign bus.mem_wr_addr_o = wr_addr;
    assign bus.mem_wr_data_o = result_buf;
    assign bus.op_a_o        = op_a;
    assign bus.op_b_o        = op_b;
    assign bus.busy_o        = busy;
    assign bus.done_o        = done;
    assign bus.carry_o       = carry;
endmodule

// File: tb/tb_calc_add_controller.sv
// Directed self-checking bench for calc_add_controller with a behavioural SRAM and adder.
// Carry expectations follow CALC_CARRY_FLAG_EN as defined for the build.
module tb_calc_add_controller;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int MEM_W  = 64;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    calc_add_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_W(MEM_W)) bus ();

    calc_add_controller #(.ADDR_W(ADDR_W), .MEM_W(MEM_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    logic [MEM_W-1:0]  mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] wr_addr_log [0:63];
    logic [MEM_W-1:0]  wr_data_log [0:63];

    int checks    = 0;
    int failures  = 0;
    int rd_cnt    = 0;
    int wr_cnt    = 0;
    int both_cnt  = 0;
    logic exp_carry;

    always #5 clk_i = ~clk_i;

    assign bus.sum_i = bus.op_a_o + bus.op_b_o;

    // Behavioural SRAM with one-cycle read latency plus a write log
    always @(posedge clk_i) begin
        if (bus.mem_rd_en_o) begin
            bus.mem_rd_data_i <= mem[bus.mem_rd_addr_o];
            rd_cnt <= rd_cnt + 1;
        end
        if (bus.mem_wr_en_o) begin
            if (wr_cnt < 64) begin
                wr_addr_log[wr_cnt] <= bus.mem_wr_addr_o;
                wr_data_log[wr_cnt] <= bus.mem_wr_data_o;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_rd_en_o && bus.mem_wr_en_o) begin
            both_cnt <= both_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Launches one run; optionally pulses start with junk addresses mid-run at cycle busy_pulse
    task automatic applyStimulus(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] re,
                                 input logic [ADDR_W-1:0] ws, input int busy_pulse, output int cyc);
        @(negedge clk_i);
        bus.read_start_addr_i  = rs;
        bus.read_end_addr_i    = re;
        bus.write_start_addr_i = ws;
        bus.start_i            = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        cyc = 1;
        checkOutput("busy_rise", {63'd0, bus.busy_o}, 64'd1);
        while (!bus.done_o && cyc < 100) begin
            if (cyc == busy_pulse) begin
                bus.start_i            = 1'b1;
                bus.read_start_addr_i  = 10'h2AA;
                bus.read_end_addr_i    = 10'h3F0;
                bus.write_start_addr_i = 10'h155;
            end else if (cyc == busy_pulse + 1) begin
                bus.start_i = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        bus.start_i = 1'b0;
        if (!bus.done_o) begin
            cyc = -1;
        end
        @(negedge clk_i);
        checkOutput("busy_fall", {63'd0, bus.busy_o}, 64'd0);
        checkOutput("done_pulse", {63'd0, bus.done_o}, 64'd0);
    endtask

    int cyc;
    int rd_base;
    int wr_base;

    initial begin
`ifdef CALC_CARRY_FLAG_EN
        exp_carry = 1'b1;
`else
        exp_carry = 1'b0;
`endif
        bus.start_i            = 1'b0;
        bus.read_start_addr_i  = '0;
        bus.read_end_addr_i    = '0;
        bus.write_start_addr_i = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[10'h000] = {32'd5, 32'd7};
        mem[10'h001] = {32'h10, 32'h20};
        mem[10'h020] = {32'd1, 32'd1};
        mem[10'h021] = {32'd2, 32'd2};
        mem[10'h022] = {32'd3, 32'd3};
        mem[10'h030] = {32'hFFFF_FFFF, 32'd2};
        mem[10'h100] = {32'd1, 32'd2};
        mem[10'h101] = {32'd3, 32'd4};
        mem[10'h102] = {32'd5, 32'd6};
        mem[10'h103] = {32'd7, 32'd8};

        repeat (3) @(negedge clk_i);
        checkOutput("rst_strobes", {60'd0, bus.mem_rd_en_o, bus.mem_wr_en_o, bus.busy_o, bus.done_o}, 64'd0);
        checkOutput("rst_carry", {63'd0, bus.carry_o}, 64'd0);
        checkOutput("rst_addrs", {44'd0, bus.mem_rd_addr_o, bus.mem_wr_addr_o}, 64'd0);
        checkOutput("rst_wdata", bus.mem_wr_data_o, 64'd0);
        checkOutput("rst_ops", {bus.op_a_o, bus.op_b_o}, 64'd0);
        rst_i = 1'b0;

        $display("[TB] two operands");
        wr_base = wr_cnt;
        applyStimulus(10'h000, 10'h001, 10'h040, 0, cyc);
        checkOutput("two_cycles", 64'(cyc), 64'd8);
        checkOutput("two_wcount", 64'(wr_cnt - wr_base), 64'd1);
        checkOutput("two_waddr", 64'(wr_addr_log[wr_base]), 64'h40);
        checkOutput("two_wdata", wr_data_log[wr_base], 64'h00000030_0000000C);

        $display("[TB] odd count");
        wr_base = wr_cnt;
        applyStimulus(10'h020, 10'h022, 10'h010, 0, cyc);
        checkOutput("odd_cycles", 64'(cyc), 64'd12);
        checkOutput("odd_wcount", 64'(wr_cnt - wr_base), 64'd2);
        checkOutput("odd_waddr0", 64'(wr_addr_log[wr_base]), 64'h10);
        checkOutput("odd_wdata0", wr_data_log[wr_base], 64'h00000004_00000002);
        checkOutput("odd_waddr1", 64'(wr_addr_log[wr_base+1]), 64'h11);
        checkOutput("odd_wdata1", wr_data_log[wr_base+1], 64'h00000000_00000006);

        $display("[TB] overflow");
        wr_base = wr_cnt;
        applyStimulus(10'h030, 10'h030, 10'h050, 0, cyc);
        checkOutput("ovf_cycles", 64'(cyc), 64'd5);
        checkOutput("ovf_wdata", wr_data_log[wr_base], 64'h00000000_00000001);
        checkOutput("ovf_carry", {63'd0, bus.carry_o}, {63'd0, exp_carry});
        repeat (3) @(negedge clk_i);
        checkOutput("ovf_carry_hold", {63'd0, bus.carry_o}, {63'd0, exp_carry});

        $display("[TB] empty range");
        rd_base = rd_cnt;
        wr_base = wr_cnt;
        applyStimulus(10'h005, 10'h004, 10'h070, 0, cyc);
        checkOutput("empty_cycles", 64'(cyc), 64'd1);
        checkOutput("empty_strobes", 64'((rd_cnt - rd_base) + (wr_cnt - wr_base)), 64'd0);
        checkOutput("empty_carry_clr", {63'd0, bus.carry_o}, 64'd0);

        $display("[TB] start while busy");
        wr_base = wr_cnt;
        applyStimulus(10'h020, 10'h022, 10'h060, 2, cyc);
        checkOutput("busy_cycles", 64'(cyc), 64'd12);
        checkOutput("busy_wcount", 64'(wr_cnt - wr_base), 64'd2);
        checkOutput("busy_waddr0", 64'(wr_addr_log[wr_base]), 64'h60);
        checkOutput("busy_wdata0", wr_data_log[wr_base], 64'h00000004_00000002);
        checkOutput("busy_waddr1", 64'(wr_addr_log[wr_base+1]), 64'h61);
        checkOutput("busy_wdata1", wr_data_log[wr_base+1], 64'h00000000_00000006);

        $display("[TB] address wrap");
        rd_base = rd_cnt;
        wr_base = wr_cnt;
        applyStimulus(10'h3FF, 10'h000, 10'h080, 0, cyc);
        checkOutput("wrap_empty_cycles", 64'(cyc), 64'd1);
        checkOutput("wrap_empty_strobes", 64'((rd_cnt - rd_base) + (wr_cnt - wr_base)), 64'd0);
        wr_base = wr_cnt;
        applyStimulus(10'h100, 10'h103, 10'h3FF, 0, cyc);
        checkOutput("wrap_cycles", 64'(cyc), 64'd15);
        checkOutput("wrap_wcount", 64'(wr_cnt - wr_base), 64'd2);
        checkOutput("wrap_waddr0", 64'(wr_addr_log[wr_base]), 64'h3FF);
        checkOutput("wrap_wdata0", wr_data_log[wr_base], 64'h00000007_00000003);
        checkOutput("wrap_waddr1", 64'(wr_addr_log[wr_base+1]), 64'h000);
        checkOutput("wrap_wdata1", wr_data_log[wr_base+1], 64'h0000000F_0000000B);

        $display("[TB] reset mid-run");
        @(negedge clk_i);
        bus.read_start_addr_i  = 10'h100;
        bus.read_end_addr_i    = 10'h103;
        bus.write_start_addr_i = 10'h200;
        bus.start_i            = 1'b1;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        checkOutput("midrst_store", {61'd0, bus.busy_o, bus.mem_rd_en_o, bus.mem_wr_en_o}, 64'b100);
        wr_base = wr_cnt;
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("midrst_strobes", {60'd0, bus.mem_rd_en_o, bus.mem_wr_en_o, bus.busy_o, bus.done_o}, 64'd0);
        checkOutput("midrst_addrs", {44'd0, bus.mem_rd_addr_o, bus.mem_wr_addr_o}, 64'd0);
        checkOutput("midrst_wdata", bus.mem_wr_data_o, 64'd0);
        checkOutput("midrst_ops", {bus.op_a_o, bus.op_b_o}, 64'd0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checkOutput("midrst_nowrite", 64'(wr_cnt - wr_base), 64'd0);
        checkOutput("midrst_idle", {63'd0, bus.busy_o}, 64'd0);

        checkOutput("no_rd_wr_overlap", 64'(both_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
